// File: rtl/mc_maindec_ext.sv
// Multicycle MIPS main control FSM with optional extended opcodes,
// variable-latency memory handshake, illegal-opcode detection and retire pulse.
// Outputs are combinational from state, op and memrdy.
module mc_maindec_ext #(
    parameter bit EXT_OPS  = 1'b1,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memrdy,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       zeroext,
    output logic       link,
    output logic       memreq,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       instret,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12,
        S_JALEX   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t cur_state;
    state_t nxt_state;
    logic   eff_rdy;

    // Memory completion as seen by the FSM; without handshake every access is single-cycle
    assign eff_rdy = MEM_WAIT ? memrdy : 1'b1;
    assign state   = cur_state;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and control output decode
    always_comb begin
        nxt_state = S_FETCH;
        pcwrite   = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        branch    = 1'b0;
        bne       = 1'b0;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        zeroext   = 1'b0;
        link      = 1'b0;
        memreq    = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        aluop     = 3'b000;
        instret   = 1'b0;
        illegal   = 1'b0;

        case (cur_state)
            S_FETCH: begin
                memreq    = 1'b1;
                alusrcb   = 2'b01;
                irwrite   = eff_rdy;
                pcwrite   = eff_rdy;
                nxt_state = eff_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:            nxt_state = S_MEMADR;
                    OP_RTYPE:                nxt_state = S_RTYPEEX;
                    OP_BEQ:                  nxt_state = S_BEQEX;
                    OP_ADDI:                 nxt_state = S_IMMEX;
                    OP_J:                    nxt_state = S_JEX;
                    OP_ANDI, OP_ORI, OP_SLTI: begin
                        nxt_state = EXT_OPS ? S_IMMEX : S_FETCH;
                        illegal   = !EXT_OPS;
                    end
                    OP_BNE: begin
                        nxt_state = EXT_OPS ? S_BNEEX : S_FETCH;
                        illegal   = !EXT_OPS;
                    end
                    OP_JAL: begin
                        nxt_state = EXT_OPS ? S_JALEX : S_FETCH;
                        illegal   = !EXT_OPS;
                    end
                    default: begin
                        nxt_state = S_FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW) begin
                    nxt_state = S_MEMRD;
                end else if (op == OP_SW) begin
                    nxt_state = S_MEMWR;
                end else begin
                    nxt_state = S_FETCH;
                end
            end
            S_MEMRD: begin
                memreq    = 1'b1;
                iord      = 1'b1;
                nxt_state = eff_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                instret  = 1'b1;
            end
            S_MEMWR: begin
                memreq    = 1'b1;
                memwrite  = 1'b1;
                iord      = 1'b1;
                instret   = eff_rdy;
                nxt_state = eff_rdy ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                aluop     = 3'b010;
                nxt_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                instret  = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 3'b001;
                branch  = 1'b1;
                pcsrc   = 2'b01;
                instret = 1'b1;
            end
            S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = 3'b001;
                bne     = 1'b1;
                pcsrc   = 2'b01;
                instret = 1'b1;
            end
            S_IMMEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = S_IMMWB;
                // op is still held in the IR, so it selects the ALU function here
                case (op)
                    OP_ANDI: begin
                        aluop   = 3'b011;
                        zeroext = 1'b1;
                    end
                    OP_ORI: begin
                        aluop   = 3'b100;
                        zeroext = 1'b1;
                    end
                    OP_SLTI: aluop = 3'b101;
                    default: aluop = 3'b000;
                endcase
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                instret  = 1'b1;
            end
            S_JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
                instret = 1'b1;
            end
            S_JALEX: begin
                pcwrite  = 1'b1;
                pcsrc    = 2'b10;
                regwrite = 1'b1;
                link     = 1'b1;
                instret  = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase

        // Reset suppresses every side effect so an aborted instruction leaves no trace
        if (reset) begin
            memreq   = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            instret  = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_maindec_ext.sv
// Directed bench for mc_maindec_ext: one instance with extended ops and memory
// handshake, one with neither.
module tb_mc_maindec_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: EXT_OPS=1, MEM_WAIT=1
    logic       rst_a, rdy_a;
    logic [5:0] op_a;
    logic       pcw_a, memw_a, irw_a, regw_a, asa_a, br_a, bn_a, iord_a;
    logic       mtr_a, rdst_a, zext_a, lnk_a, mreq_a, iret_a, ill_a;
    logic [1:0] asb_a, pcs_a;
    logic [2:0] aop_a;
    logic [3:0] st_a;

    // Instance B: EXT_OPS=0, MEM_WAIT=0
    logic       rst_b, rdy_b;
    logic [5:0] op_b;
    logic       pcw_b, memw_b, irw_b, regw_b, asa_b, br_b, bn_b, iord_b;
    logic       mtr_b, rdst_b, zext_b, lnk_b, mreq_b, iret_b, ill_b;
    logic [1:0] asb_b, pcs_b;
    logic [2:0] aop_b;
    logic [3:0] st_b;

    mc_maindec_ext #(.EXT_OPS(1'b1), .MEM_WAIT(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .op(op_a), .memrdy(rdy_a),
        .pcwrite(pcw_a), .memwrite(memw_a), .irwrite(irw_a), .regwrite(regw_a),
        .alusrca(asa_a), .branch(br_a), .bne(bn_a), .iord(iord_a),
        .memtoreg(mtr_a), .regdst(rdst_a), .zeroext(zext_a), .link(lnk_a),
        .memreq(mreq_a), .alusrcb(asb_a), .pcsrc(pcs_a), .aluop(aop_a),
        .instret(iret_a), .illegal(ill_a), .state(st_a)
    );

    mc_maindec_ext #(.EXT_OPS(1'b0), .MEM_WAIT(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .op(op_b), .memrdy(rdy_b),
        .pcwrite(pcw_b), .memwrite(memw_b), .irwrite(irw_b), .regwrite(regw_b),
        .alusrca(asa_b), .branch(br_b), .bne(bn_b), .iord(iord_b),
        .memtoreg(mtr_b), .regdst(rdst_b), .zeroext(zext_b), .link(lnk_b),
        .memreq(mreq_b), .alusrcb(asb_b), .pcsrc(pcs_b), .aluop(aop_b),
        .instret(iret_b), .illegal(ill_b), .state(st_b)
    );

    // Output vector: {pcwrite,memwrite,irwrite,regwrite, alusrca,branch,bne,iord,
    // memtoreg,regdst,zeroext,link, memreq, alusrcb, pcsrc, aluop, instret, illegal, state}
    logic [25:0] va, vb;
    assign va = {pcw_a, memw_a, irw_a, regw_a, asa_a, br_a, bn_a, iord_a,
                 mtr_a, rdst_a, zext_a, lnk_a, mreq_a, asb_a, pcs_a, aop_a,
                 iret_a, ill_a, st_a};
    assign vb = {pcw_b, memw_b, irw_b, regw_b, asa_b, br_b, bn_b, iord_b,
                 mtr_b, rdst_b, zext_b, lnk_b, mreq_b, asb_b, pcs_b, aop_b,
                 iret_b, ill_b, st_b};

    function automatic logic [25:0] mk(input logic [3:0] st, input logic [3:0] we,
                                       input logic [7:0] sel, input logic mreq,
                                       input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic [2:0] aop, input logic iret,
                                       input logic ill);
        return {we, sel, mreq, asb, pcs, aop, iret, ill, st};
    endfunction

    task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; rdy_a = 1'b0; op_a = 6'b0;
        rst_b = 1'b1; rdy_b = 1'b0; op_b = 6'b0;
        @(negedge clk);
        @(negedge clk);

        // ---------------- Instance B: EXT_OPS=0, MEM_WAIT=0 ----------------
        rst_b = 1'b1; rdy_b = 1'b1; #1;
        chk("b reset gating", vb, mk(4'd0, 4'b0000, 8'h00, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        rst_b = 1'b0;

        // lw with memrdy low everywhere: handshake ignored
        op_b = 6'b100011; rdy_b = 1'b0; #1;
        chk("b lw fetch", vb, mk(4'd0, 4'b1010, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("b lw decode", vb, mk(4'd1, 4'b0000, 8'h00, 1'b0, 2'b11, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("b lw memadr", vb, mk(4'd2, 4'b0000, 8'h80, 1'b0, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("b lw memrd", vb, mk(4'd3, 4'b0000, 8'h10, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("b lw memwb", vb, mk(4'd4, 4'b0001, 8'h08, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
        @(negedge clk);

        // bne is illegal without extended ops
        op_b = 6'b000101; #1;
        chk("b bne fetch", vb, mk(4'd0, 4'b1010, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("b bne illegal", vb, mk(4'd1, 4'b0000, 8'h00, 1'b0, 2'b11, 2'b00, 3'b000, 1'b0, 1'b1));
        @(negedge clk);

        // R-type
        op_b = 6'b000000; #1;
        chk("b rtype back to fetch", vb, mk(4'd0, 4'b1010, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk); #1;
        chk("b rtypeex", vb, mk(4'd6, 4'b0000, 8'h80, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("b rtypewb", vb, mk(4'd7, 4'b0001, 8'h04, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
        @(negedge clk); #1;
        chk("b rtype done", vb, mk(4'd0, 4'b1010, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        rst_b = 1'b1;

        // ---------------- Instance A: EXT_OPS=1, MEM_WAIT=1 ----------------
        @(negedge clk);
        rst_a = 1'b0;

        // sw with three wait cycles in MEMWR
        op_a = 6'b101011; rdy_a = 1'b1; #1;
        chk("a sw fetch", va, mk(4'd0, 4'b1010, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("a sw decode", va, mk(4'd1, 4'b0000, 8'h00, 1'b0, 2'b11, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("a sw memadr", va, mk(4'd2, 4'b0000, 8'h80, 1'b0, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        rdy_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("a sw memwr wait", va, mk(4'd5, 4'b0100, 8'h10, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
            @(negedge clk);
        end
        rdy_a = 1'b1; #1;
        chk("a sw memwr done", va, mk(4'd5, 4'b0100, 8'h10, 1'b1, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
        @(negedge clk);

        // ori with one FETCH wait cycle
        op_a = 6'b001101; rdy_a = 1'b0; #1;
        chk("a fetch wait", va, mk(4'd0, 4'b0000, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        rdy_a = 1'b1; #1;
        chk("a ori fetch", va, mk(4'd0, 4'b1010, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk); #1;
        chk("a ori immex", va, mk(4'd9, 4'b0000, 8'h82, 1'b0, 2'b10, 2'b00, 3'b100, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("a ori immwb", va, mk(4'd10, 4'b0001, 8'h00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
        @(negedge clk);

        // slti
        op_a = 6'b001010;
        @(negedge clk);
        @(negedge clk); #1;
        chk("a slti immex", va, mk(4'd9, 4'b0000, 8'h80, 1'b0, 2'b10, 2'b00, 3'b101, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);

        // bne
        op_a = 6'b000101; #1;
        chk("a bne fetch", va, mk(4'd0, 4'b1010, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk); #1;
        chk("a bneex", va, mk(4'd12, 4'b0000, 8'hA0, 1'b0, 2'b00, 2'b01, 3'b001, 1'b1, 1'b0));
        @(negedge clk);

        // jal
        op_a = 6'b000011;
        @(negedge clk); #1;
        chk("a jal decode", va, mk(4'd1, 4'b0000, 8'h00, 1'b0, 2'b11, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk); #1;
        chk("a jalex", va, mk(4'd13, 4'b1001, 8'h01, 1'b0, 2'b00, 2'b10, 3'b000, 1'b1, 1'b0));
        @(negedge clk); #1;
        chk("a jal done", va, mk(4'd0, 4'b1010, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));

        // lw aborted by reset while waiting in MEMRD
        op_a = 6'b100011;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rdy_a = 1'b0; #1;
        chk("a lw memrd wait", va, mk(4'd3, 4'b0000, 8'h10, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        rst_a = 1'b1; #1;
        chk("a reset in memrd", va, mk(4'd3, 4'b0000, 8'h10, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        rst_a = 1'b0; #1;
        chk("a after abort", va, mk(4'd0, 4'b0000, 8'h00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_maindec_ext.md
# mc_maindec_ext

Parametrised multicycle MIPS main control FSM, the successor of the fixed six-opcode decoder. It sits in the multicycle controller beside the ALU decoder and drives all datapath enables and mux selects. It adds optional extended opcodes (andi, ori, slti, bne, jal), an optional variable-latency memory handshake, illegal-opcode detection, and an instruction-retire pulse.

## Interface
- EXT_OPS, default 1: 1 decodes andi/ori/slti/bne/jal; 0 treats them as illegal.
- MEM_WAIT, default 1: 1 means memory states wait for memrdy; 0 means memrdy is ignored and treated as 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; state becomes FETCH on the next edge.
- op  in  6  instruction opcode from the instruction register.
- memrdy  in  1  memory completes the current request this cycle.
- pcwrite, memwrite, irwrite, regwrite  out  1 each  write enables.
- alusrca, branch, bne, iord, memtoreg, regdst, zeroext, link  out  1 each  datapath selects and qualifiers.
- memreq  out  1  memory access request.
- alusrcb, pcsrc  out  2 each  mux selects.
- aluop  out  3  ALU operation: 000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt.
- instret  out  1  one-cycle pulse in the final cycle of each legal instruction.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- state  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, BNEEX 12, JALEX 13.
- Every output not listed for a state is 0.
- FETCH: memreq=1, alusrcb=01, aluop=000, pcsrc=00.
  - irwrite and pcwrite equal the effective memrdy.
  - If the effective memrdy is 1, go to DECODE; otherwise stay in FETCH.
- DECODE: alusrcb=11, aluop=000.
  - lw/sw go to MEMADR; R-type (000000) to RTYPEEX; beq to BEQEX; addi to IMMEX; j to JEX.
  - With EXT_OPS=1 only: andi (001100), ori (001101) and slti (001010) go to IMMEX; bne (000101) to BNEEX; jal (000011) to JALEX.
  - Any other opcode: illegal=1, go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=000. lw goes to MEMRD, sw goes to MEMWR.
- MEMRD: memreq=1, iord=1. Goes to MEMWB on effective memrdy; otherwise holds.
- MEMWB: regwrite=1, memtoreg=1, instret=1. Goes to FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1, held constant while waiting.
  - On effective memrdy: instret=1, go to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=010. Goes to RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, instret=1. Goes to FETCH.
- BEQEX: alusrca=1, aluop=001, branch=1, pcsrc=01, instret=1. Goes to FETCH.
- BNEEX: same as BEQEX but bne=1 instead of branch=1.
- IMMEX: alusrca=1, alusrcb=10. Goes to IMMWB.
  - aluop is 000 for addi, 011 for andi, 100 for ori, 101 for slti.
  - zeroext=1 for andi and ori.
  - op is stable from the IR until the next FETCH.
- IMMWB: regwrite=1, instret=1. Goes to FETCH.
- JEX: pcwrite=1, pcsrc=10, instret=1. Goes to FETCH.
- JALEX: pcwrite=1, pcsrc=10, regwrite=1, link=1, instret=1. Goes to FETCH.
  - The datapath writes the already-incremented PC to $31.
- Unreachable state encodings (14, 15) go to FETCH, with all outputs 0.

## Timing
- Outputs are purely combinational from state, op and memrdy. There are no registered outputs.
- Reset:
  - While reset is high, memreq, memwrite, regwrite, pcwrite, irwrite, instret and illegal are forced to 0.
  - After the edge, state=0 and outputs take their FETCH values.
  - Reset asserted mid-instruction (including during a memory wait) aborts it; no instret is issued.
- Latency in cycles with MEM_WAIT=0, FETCH through the last state: lw 5, sw 4, R-type 4, I-type ALU 4, beq/bne 3, j 3, jal 3, illegal 2.
- With MEM_WAIT=1, each of FETCH, MEMRD and MEMWR adds one cycle per cycle that memrdy is low.
- memrdy while memreq=0 is ignored.
- memrdy high in the first cycle of a memory state means zero wait: latency is the same as with MEM_WAIT=0.
- memrdy high during reset has no effect.

## Test plan
- Reset with MEM_WAIT=0, then lw (100011): state goes 0,1,2,3,4,0.
  - irwrite is high in cycle 0, memtoreg and regwrite in cycle 4.
  - instret is high only in cycle 4.
- MEM_WAIT=1, sw (101011), memrdy low for 3 cycles in MEMWR:
  - state is held at 5 for 4 cycles with memwrite=1 and iord=1 steady.
  - instret pulses once, then the FSM returns to FETCH.
- EXT_OPS=1, ori (001101): state goes 0,1,9,10,0.
  - In IMMEX, aluop=100 and zeroext=1.
  - slti gives aluop=101 and zeroext=0.
- EXT_OPS=0, bne (000101): illegal=1 in DECODE, next state 0, no instret.
  - With EXT_OPS=1, the FSM goes to 12 with bne=1, pcsrc=01, aluop=001.
- jal (000011): state goes 0,1,13.
  - In JALEX: pcwrite=1, pcsrc=10, regwrite=1, link=1; then 0.
- Reset asserted in MEMRD while memrdy is low:
  - the next state is 0, no regwrite occurs, and memreq is 0 during the reset cycle.
